// File: rtl/grf_scoreboard.sv
// Decode-stage general register file with write-through bypass and a Tuse/Tnew hazard scoreboard.
// Optional GRF_TRACE_EN prints a line for each committed write; synthesised logic is unchanged.
module grf_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned TNEW_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [31:0]              wpc,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*TNEW_W-1:0] rd_tuse,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dst,
    input  logic [TNEW_W-1:0]        iss_tnew,
    input  logic                     flush,
    output logic                     stall,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int unsigned NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [TNEW_W-1:0] r_cnt  [NREG];
    logic [NUM_RD-1:0] w_port_stall;
    logic              w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Each port is bypassed and hazard-checked independently.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [TNEW_W-1:0] w_tuse;

        assign w_ra   = raddr[g*ADDR_W +: ADDR_W];
        assign w_tuse = rd_tuse[g*TNEW_W +: TNEW_W];

        assign rdata[g*DATA_W +: DATA_W] =
            (w_ra == '0)              ? '0    :
            (we && (waddr == w_ra))   ? wdata :
                                        r_regs[w_ra];

        assign w_port_stall[g] = rd_en[g] && (w_ra != '0) && r_busy[w_ra] &&
                                 (r_cnt[w_ra] > w_tuse);
    end

    // Stall depends only on read-side inputs and scoreboard state, never on iss_*.
    assign stall    = |w_port_stall;
    assign w_accept = iss_valid && !stall && (iss_dst != '0);
    assign busy     = r_busy;

    // Priority per register: reset/flush, then accept, then writeback, then countdown.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREG; r++) begin
            if (reset || flush) begin
                r_busy[r] <= 1'b0;
                r_cnt[r]  <= '0;
            end else if (w_accept && (iss_dst == ADDR_W'(r))) begin
                r_busy[r] <= 1'b1;
                r_cnt[r]  <= iss_tnew;
            end else if (we && (waddr == ADDR_W'(r))) begin
                r_busy[r] <= 1'b0;
                r_cnt[r]  <= '0;
            end else if (r_cnt[r] != '0) begin
                r_cnt[r]  <= r_cnt[r] - TNEW_W'(1);
            end
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && we && (waddr != '0)) begin
            $display("@%h: $%d <= %h", wpc, waddr, wdata);
        end
    end
`else
    logic w_unused_wpc;
    assign w_unused_wpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed table-driven bench for grf_scoreboard plus hand sequences for countdown and reset.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wpc;
    logic [9:0]  raddr;
    logic [1:0]  rd_en;
    logic [5:0]  rd_tuse;
    logic [63:0] rdata;
    logic        iss_valid;
    logic [4:0]  iss_dst;
    logic [2:0]  iss_tnew;
    logic        flush;
    logic        stall;
    logic [31:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .TNEW_W(3)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wpc(wpc),
        .raddr(raddr), .rd_en(rd_en), .rd_tuse(rd_tuse), .rdata(rdata),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_tnew(iss_tnew),
        .flush(flush), .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  rd_en;
        logic [2:0]  tu0;
        logic [2:0]  tu1;
        logic        iv;
        logic [4:0]  dst;
        logic [2:0]  tnew;
        logic        flush;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_stall;
        logic [31:0] e_busy;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v);
        we        = v.we;
        waddr     = v.waddr;
        wdata     = v.wdata;
        raddr     = {v.ra1, v.ra0};
        rd_en     = v.rd_en;
        rd_tuse   = {v.tu1, v.tu0};
        iss_valid = v.iv;
        iss_dst   = v.dst;
        iss_tnew  = v.tnew;
        flush     = v.flush;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int stall_cycles;

        // Checks reflect state before the row's edge, with the row's inputs applied.
        tbl[0]  = '{1'b0, 5'd0, 32'h0,        5'd1, 5'd2,  2'b11, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5,  2'b00, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0,  2'b00, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0};
        tbl[3]  = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5,  2'b00, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5,  2'b00, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd1, 5'd2,  2'b00, 3'd0, 3'd0, 1'b1, 5'd8,  3'd2, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd0,  2'b01, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h100};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd0,  2'b01, 3'd0, 3'd0, 1'b1, 5'd9,  3'd4, 1'b0, 32'h0,        32'h0,        1'b1, 32'h100};
        tbl[8]  = '{1'b1, 5'd8, 32'hA5A5A5A5, 5'd8, 5'd0,  2'b01, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0, 32'h100};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd0,  2'b01, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0, 32'h0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd0,  2'b00, 3'd0, 3'd0, 1'b1, 5'd8,  3'd1, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0, 32'h0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd8,  2'b01, 3'd1, 3'd0, 1'b1, 5'd12, 3'd3, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h100};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd12, 2'b10, 3'd0, 3'd2, 1'b0, 5'd0,  3'd0, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b1, 32'h1100};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd12, 2'b10, 3'd0, 3'd2, 1'b0, 5'd0,  3'd0, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0, 32'h1100};
        tbl[14] = '{1'b1, 5'd3, 32'h0BADF00D, 5'd3, 5'd12, 2'b00, 3'd0, 3'd0, 1'b1, 5'd3,  3'd3, 1'b0, 32'h0BADF00D, 32'h0,        1'b0, 32'h1100};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd12, 2'b01, 3'd2, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'h0BADF00D, 32'h0,        1'b1, 32'h1108};
        tbl[16] = '{1'b1, 5'd7, 32'h77,       5'd3, 5'd7,  2'b00, 3'd0, 3'd0, 1'b1, 5'd20, 3'd2, 1'b1, 32'h0BADF00D, 32'h77,       1'b0, 32'h1108};
        tbl[17] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd3,  2'b11, 3'd0, 3'd0, 1'b0, 5'd0,  3'd0, 1'b0, 32'h77,       32'h0BADF00D, 1'b0, 32'h0};

        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wpc = 32'h0000_3000;
        raddr = '0; rd_en = '0; rd_tuse = '0; iss_valid = 1'b0; iss_dst = '0;
        iss_tnew = '0; flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (i != 0) @(negedge clk);
            apply(tbl[i]);
            wpc = 32'h0000_3000 + 32'(i * 4);
            #2;
            chk($sformatf("row%0d rdata0", i), rdata[31:0],  tbl[i].e_rd0);
            chk($sformatf("row%0d rdata1", i), rdata[63:32], tbl[i].e_rd1);
            chk($sformatf("row%0d stall", i),  {31'b0, stall}, {31'b0, tbl[i].e_stall});
            chk($sformatf("row%0d busy", i),   busy, tbl[i].e_busy);
        end

        // Long countdown: tnew=7 with tuse=0 stalls exactly seven cycles, then saturates at 0.
        @(negedge clk);
        we = 1'b0; flush = 1'b0; rd_en = 2'b00; raddr = '0; rd_tuse = '0;
        iss_valid = 1'b1; iss_dst = 5'd15; iss_tnew = 3'd7;
        #2;
        chk("countdown accept stall", {31'b0, stall}, 32'h0);
        stall_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            iss_valid = 1'b0; iss_dst = '0; iss_tnew = '0;
            raddr = {5'd0, 5'd15}; rd_en = 2'b01; rd_tuse = 6'd0;
            #2;
            if (stall) stall_cycles++;
            else break;
        end
        chk("countdown stall cycles", 32'(stall_cycles), 32'd7);
        chk("countdown busy15", {31'b0, busy[15]}, 32'h1);
        @(negedge clk);
        #2;
        chk("countdown saturate", {31'b0, stall}, 32'h0);

        // Reset mid-operation overrides a simultaneous write and accept.
        @(negedge clk);
        rd_en = 2'b00; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        @(negedge clk);
        reset = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        iss_valid = 1'b1; iss_dst = 5'd6; iss_tnew = 3'd3;
        raddr = {5'd0, 5'd4};
        #2;
        chk("prereset reg4", rdata[31:0], 32'h44);
        @(negedge clk);
        reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; iss_valid = 1'b0;
        raddr = {5'd9, 5'd4}; rd_en = 2'b11; rd_tuse = '0;
        #2;
        chk("postreset reg4", rdata[31:0], 32'h0);
        chk("postreset reg9", rdata[63:32], 32'h0);
        chk("postreset busy", busy, 32'h0);
        chk("postreset stall", {31'b0, stall}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
